// File: rtl/sort_pkg.sv
// Shared constants and helpers for the 4-input sorting path.
// The pad value is the element that always sorts to the minimum position.
package sort_pkg;

  localparam int NUM_ELEMS  = 4;
  localparam int CNT_WD     = 3;
  localparam int IDX_WD     = $clog2(NUM_ELEMS);
  localparam int NUM_SLOTS  = 2;
  localparam int PAD_MAX_WD = 64;

  // Most negative value for signed elements, zero otherwise; callers cast to their width.
  function automatic logic [PAD_MAX_WD-1:0] pad_value(input int unsigned wd, input bit is_signed);
    logic [PAD_MAX_WD-1:0] pad;
    pad = '0;
    if (is_signed && wd > 0) pad = PAD_MAX_WD'(1) << (wd - 1);
    return pad;
  endfunction

endpackage

// File: rtl/sort_frame_slot.sv
// One frame buffer slot: four entries, full flag and element count.
// Draining returns every entry to PAD so a later short frame never shows stale data.
module sort_frame_slot
  import sort_pkg::*;
#(
  parameter int DATA_WD = 8,
  parameter int SIGNED  = 0
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_wr_en,
  input  logic [IDX_WD-1:0]                 i_wr_idx,
  input  logic [DATA_WD-1:0]                i_wr_data,
  input  logic                              i_close,
  input  logic [CNT_WD-1:0]                 i_close_count,
  input  logic                              i_drain,
  output logic [NUM_ELEMS-1:0][DATA_WD-1:0] o_entries,
  output logic                              o_full,
  output logic [CNT_WD-1:0]                 o_count
);

  localparam logic [DATA_WD-1:0] PAD = DATA_WD'(pad_value(DATA_WD, SIGNED != 0));

  logic [NUM_ELEMS-1:0][DATA_WD-1:0] entries_q, entries_d;
  logic                              full_q, full_d;
  logic [CNT_WD-1:0]                 count_q, count_d;

  // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    entries_d = entries_q;
    full_d    = full_q;
    count_d   = count_q;
    if (i_drain) begin
      entries_d = {NUM_ELEMS{PAD}};
      full_d    = 1'b0;
      count_d   = '0;
    end
    // Write and drain never target the same slot, so their order here is irrelevant.
    if (i_wr_en) entries_d[i_wr_idx] = i_wr_data;
    if (i_close) begin
      full_d  = 1'b1;
      count_d = i_close_count;
    end
  end

  // NOTE: the entry array is reset (to PAD, not zero) because unused positions of a short frame are read as real pad values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      entries_q <= {NUM_ELEMS{PAD}};
      full_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
      entries_q <= entries_d;
      full_q    <= full_d;
      count_q   <= count_d;
    end
  end

  assign o_entries = entries_q;
  assign o_full    = full_q;
  assign o_count   = count_q;

endmodule

// File: rtl/sort_frame_gather.sv
// Packs a scalar valid/ready stream into 4-element frames through a ping-pong pair of slots.
// Outputs are a pure mux of registered slot state; no input-to-output combinational path.
module sort_frame_gather
  import sort_pkg::*;
#(
  parameter int DATA_WD = 8,
  parameter int SIGNED  = 0
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [DATA_WD-1:0]                i_data,
  input  logic                              i_valid,
  input  logic                              i_last,
  output logic                              o_ready,
  output logic [NUM_ELEMS-1:0][DATA_WD-1:0] o_frame,
  output logic [CNT_WD-1:0]                 o_frame_count,
  output logic                              o_valid,
  input  logic                              i_ready
);

  logic [IDX_WD-1:0] cnt_q, cnt_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;

  logic [NUM_SLOTS-1:0]                              slot_full;
  logic [NUM_SLOTS-1:0]                              slot_wr_en;
  logic [NUM_SLOTS-1:0]                              slot_close;
  logic [NUM_SLOTS-1:0]                              slot_drain;
  logic [NUM_SLOTS-1:0][NUM_ELEMS-1:0][DATA_WD-1:0]  slot_entries;
  logic [NUM_SLOTS-1:0][CNT_WD-1:0]                  slot_count;

  logic              beat_acc;
  logic              frame_acc;
  logic              frame_close;
  logic [CNT_WD-1:0] close_count;

  assign o_ready       = !slot_full[wr_sel_q];
  assign o_valid       = slot_full[rd_sel_q];
  assign o_frame       = slot_entries[rd_sel_q];
  assign o_frame_count = slot_count[rd_sel_q];

  always_comb begin
    beat_acc    = i_valid && o_ready;
    frame_acc   = o_valid && i_ready;
    frame_close = beat_acc && (i_last || cnt_q == IDX_WD'(NUM_ELEMS - 1));
    close_count = CNT_WD'(cnt_q) + CNT_WD'(1);
    cnt_d       = cnt_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    slot_wr_en  = '0;
    slot_close  = '0;
    slot_drain  = '0;
    if (beat_acc) begin
      slot_wr_en[wr_sel_q] = 1'b1;
      if (frame_close) begin
        slot_close[wr_sel_q] = 1'b1;
        cnt_d                = '0;
        wr_sel_d             = !wr_sel_q;
      end else begin
        cnt_d = cnt_q + IDX_WD'(1);
      end
    end
    // The filling slot is never full, so a same-cycle drain always hits the other slot.
    if (frame_acc) begin
      slot_drain[rd_sel_q] = 1'b1;
      rd_sel_d             = !rd_sel_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q    <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    sort_frame_slot #(
      .DATA_WD (DATA_WD),
      .SIGNED  (SIGNED)
    ) u_slot (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_wr_en       (slot_wr_en[s]),
      .i_wr_idx      (cnt_q),
      .i_wr_data     (i_data),
      .i_close       (slot_close[s]),
      .i_close_count (close_count),
      .i_drain       (slot_drain[s]),
      .o_entries     (slot_entries[s]),
      .o_full        (slot_full[s]),
      .o_count       (slot_count[s])
    );
  end

endmodule

// File: doc/sort_frame_gather.md
Name: sort_frame_gather

Overview:
Upstream feeder for the 4-input sorting network. Accepts a scalar stream under valid/ready, one element per beat, and packs beats into 4-element frames. Short frames closed by i_last are padded. Completed frames are presented as a 4-wide vector under valid/ready. A two-slot ping-pong buffer lets one frame fill while the previous frame waits on the consumer.

Parameters:
DATA_WD, 8, element width in bits
SIGNED, 0, 1 = elements are two's complement; selects PAD value

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  asynchronous, active-high reset
i_data  input  DATA_WD  stream element
i_valid  input  1  i_data valid
i_last  input  1  qualifies current beat as final element of frame (early close)
o_ready  output  1  block can accept a beat this cycle
o_frame  output  DATA_WD x [4]  frame vector; index k = k-th accepted beat of frame
o_frame_count  output  3  number of real (non-pad) elements in o_frame, 1..4 (0 when o_valid=0 after reset)
o_valid  output  1  o_frame/o_frame_count valid
i_ready  input  1  consumer accepts frame this cycle

Behaviour:
- Interface (decided): one clock, i_clk; reset i_rst, asynchronous, active-high.
- PAD = 0 when SIGNED=0; PAD = {1'b1, (DATA_WD-1){1'b0}} (most negative) when SIGNED=1. Pad always sorts to the minimum position.
- State: two slots (0,1), each with 4 x DATA_WD entries, full flag and 3-bit count. Also wr_sel, rd_sel (1 bit each) and element counter cnt (2 bits).
- Reset (async, immediate):
  - all entries = PAD; full = 0; counts = 0; wr_sel = rd_sel = 0; cnt = 0.
  - Outputs: o_valid = 0, o_ready = 1, o_frame = all PAD, o_frame_count = 0.
  - A partial frame is discarded. Reset mid-handshake drops the pending frame.
- o_ready = !full[wr_sel]. Depends only on registered state; no combinational path from i_valid or i_ready.
- Beat accept (i_valid & o_ready):
  - slot[wr_sel].entry[cnt] <= i_data.
  - If cnt==3 or i_last: full[wr_sel] <= 1, count[wr_sel] <= cnt+1, cnt <= 0, wr_sel toggles.
  - Else: cnt <= cnt+1.
- i_last on first beat gives count 1, entries 1..3 = PAD. i_last with cnt==3 is identical to a normal close.
- i_last without i_valid is ignored. i_data and i_last are don't-care when the beat is not accepted.
- Output: o_valid = full[rd_sel]; o_frame = slot[rd_sel].entries; o_frame_count = count[rd_sel]. Zero-latency mux of registered state.
- Frame accept (o_valid & i_ready):
  - full[rd_sel] <= 0; all 4 entries of that slot <= PAD; count <= 0; rd_sel toggles.
  - This guarantees unused positions read as PAD on the next frame.
- Stability: while o_valid & !i_ready, o_frame and o_frame_count hold constant.
- Latency: a frame is visible on o_valid the cycle after its closing beat is accepted.
- Throughput: 1 beat/cycle sustained if the consumer takes a frame at least once per 4 cycles.
- Both full: o_ready = 0 until the consumer drains one slot. o_ready rises the cycle after the drain.
- Simultaneous close of slot wr_sel and drain of slot rd_sel in one cycle is legal. The two are always different slots because the filling slot is never full.
- Data is passed through unmodified; SIGNED affects only PAD.

Decomposition:
- Package sort_pkg:
  - NUM_ELEMS = 4
  - CNT_WD = 3
  - a pad-value function parameterised by width and signedness, shared with the sorting stage.
- One natural sub-module, sort_frame_slot: one slot's storage, full flag, count, write-entry, close and drain/clear-to-PAD controls. Instantiated twice. Top holds cnt, wr_sel, rd_sel and the output mux.

Test Plan:
- Reset, then 4 beats 0x13,0x07,0xF0,0x55 with i_ready=1 -> one cycle after 4th accept: o_valid=1, o_frame={0x13,0x07,0xF0,0x55}, o_frame_count=4; o_valid drops the next cycle.
- SIGNED=1, beats 0x05,0x7F with i_last on 2nd -> o_frame={0x05,0x7F,0x80,0x80}, count=2. Repeat SIGNED=0 -> pads 0x00.
- i_ready=0, stream 12 continuous beats -> frames 1 and 2 held; o_ready=0 after beat 8. Assert i_ready for 1 cycle -> frame 1 out; o_ready=1 next cycle; frame 2 stable throughout.
- Short frame (count 1, 0xAA) followed by a full frame 1,2,3,4 reusing that slot -> second-use slot shows {1,2,3,4} with no stale 0xAA.
- Assert i_rst mid-frame after 2 beats and while o_valid=1 -> immediately o_valid=0, o_ready=1, o_frame all PAD, count 0. Next 4 beats form a clean frame at index 0.
- Random valid/ready backpressure, 1000 beats with random i_last -> scoreboard matches frame contents, counts and order; no beat lost or duplicated.
